csr_access_unit: RTL
====================

CSR_ACCESS_UNIT -- requirements
Module: csr_access_unit

Interface
REQ-001 SHALL have these ports: clk  in  1  sole clock, rising edge; reset_n  in  1  asynchronous, active-low reset.
REQ-002 SHALL have these request ports: req_valid  in  1  Zicsr instruction offered; req_ready  out  1  unit can accept; req_funct3  in  3  instruction funct3; req_csr  in  12  CSR address; req_rs1_idx  in  5  rs1 field, also uimm; req_rs1_value  in  32  rs1 register value; req_rd  in  5  destination register.
REQ-003 SHALL have these CSR bus ports: csr_number  out  12  CSR address; csr_access_type  out  2  READ_ONLY/WRITE/SET/CLEAR; csr_wdata  out  32  write operand; csr_rdata  in  32  combinational pre-write CSR value.
REQ-004 SHALL have these writeback ports: wb_valid  out  1  result available; wb_ready  in  1  consumer takes result; wb_rd  out  5  destination; wb_data  out  32  old CSR value; wb_illegal  out  1  illegal-instruction flag.

Function
REQ-005 SHALL implement a 3-state FSM: IDLE (req_ready=1), ACCESS (exactly one cycle), WB (wb_valid=1).
REQ-006 SHALL, in IDLE on req_valid&req_ready at edge N, capture all req_* fields and enter ACCESS; ACCESS spans cycle N+1; wb_valid=1 from cycle N+2.
REQ-007 SHALL drive csr_access_type=READ_ONLY in every state other than ACCESS, because the responder commits any non-READ_ONLY type on each clock edge.
REQ-008 SHALL map funct3 001/101 to WRITE, 010/110 to SET, 011/111 to CLEAR; SET/CLEAR with req_rs1_idx==0 SHALL become READ_ONLY.
REQ-009 SHALL drive csr_wdata = req_rs1_value for funct3[2]=0 and zero-extended req_rs1_idx (uimm) for funct3[2]=1.
REQ-010 SHALL sample csr_rdata into wb_data at the end of ACCESS, the same edge that commits the CSR write, so wb_data is the pre-write value.
REQ-011 SHALL perform CSRRW/CSRRWI with rd=0 as a normal write and still emit writeback with wb_rd=0.
REQ-012 SHALL hold wb_rd/wb_data/wb_illegal stable while wb_valid=1 and wb_ready=0; on wb_ready SHALL return to IDLE.
REQ-013 SHALL keep req_ready=0 in ACCESS and WB, with no request overlap; throughput is one instruction per 3 cycles minimum.

Reset
REQ-014 SHALL, on reset_n=0, immediately force state=IDLE, req_ready=1, wb_valid=0, wb_rd=0, wb_data=0, wb_illegal=0, csr_access_type=READ_ONLY, csr_number=0, csr_wdata=0.
REQ-015 SHALL abort an in-flight ACCESS on reset assertion without any CSR write, since csr_access_type drops to READ_ONLY asynchronously.

Configuration
REQ-016 SHALL, with CSR_ILLEGAL_CHECK_EN defined, flag an instruction as illegal when funct3 is 000 or 100, or when the access type is not READ_ONLY and req_csr[11:10]==2'b11.
REQ-017 SHALL, when an instruction is illegal, still take the ACCESS cycle with csr_access_type forced to READ_ONLY, then present wb_illegal=1, wb_data=0 and unchanged latency.
REQ-018 SHALL, with CSR_ILLEGAL_CHECK_EN undefined, tie wb_illegal to 0, treat funct3 000/100 as READ_ONLY, and perform writes to read-only-space addresses.

Structure
REQ-019 SHALL take the access-type typedef/encodings (values identical to csr.h CSR_READ_ONLY/WRITE/SET/CLEAR) and the funct3 constants from shared package csr_pkg.
REQ-020 SHALL contain one sub-module, csr_access_decode: a combinational mapping of funct3, rs1_idx, csr and rs1_value to access_type, wdata and illegal.

Verification
REQ-021 SHALL cover: CSRRS rd=5, csr=0x301, rs1_idx=0 -> csr_access_type READ_ONLY throughout; wb_rd=5, wb_data=0x40000100 at N+2.
REQ-022 SHALL cover: CSRRW csr=0x305, rs1_value=0x80000000 after reset -> wb_data=0; a following CSRRS x0 read of 0x305 -> wb_data=0x80000000.
REQ-023 SHALL cover: CSRRSI 0x300 uimm=8, then CSRRCI 0x300 uimm=8 -> second wb_data=0x8; a subsequent read of 0x300 returns 0.
REQ-024 SHALL cover: wb_ready held low 3 cycles -> wb_valid/wb_data stable, req_ready=0, csr_access_type READ_ONLY, no second write.
REQ-025 SHALL cover, with CSR_ILLEGAL_CHECK_EN defined: CSRRW to 0xF11 -> wb_illegal=1, wb_data=0, no non-READ_ONLY cycle; funct3=100 -> wb_illegal=1.
REQ-026 SHALL cover: reset_n pulsed low mid-ACCESS of CSRRW 0x341 value 0x1234 -> mepc unchanged (0), IDLE with req_ready=1 after release.

Source files
------------

// File: rtl/csr_pkg.sv
// Shared CSR definitions: access-type encodings matching csr.h, Zicsr funct3 values,
// unit FSM states and the captured-request record.
package csr_pkg;

    typedef enum logic [1:0] {
        CSR_READ_ONLY = 2'd0,
        CSR_WRITE     = 2'd1,
        CSR_SET       = 2'd2,
        CSR_CLEAR     = 2'd3
    } csr_access_t;

    localparam logic [2:0] FUNCT3_CSRRW  = 3'b001;
    localparam logic [2:0] FUNCT3_CSRRS  = 3'b010;
    localparam logic [2:0] FUNCT3_CSRRC  = 3'b011;
    localparam logic [2:0] FUNCT3_CSRRWI = 3'b101;
    localparam logic [2:0] FUNCT3_CSRRSI = 3'b110;
    localparam logic [2:0] FUNCT3_CSRRCI = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_WB     = 2'd2
    } state_t;

    typedef struct packed {
        logic [2:0]  funct3;
        logic [11:0] csr;
        logic [4:0]  rs1_idx;
        logic [31:0] rs1_value;
        logic [4:0]  rd;
    } csr_req_t;

endpackage

// File: rtl/csr_access_unit_if.sv
// Request, CSR-bus and writeback signals of the CSR access unit.
// slave = the unit, master = the surrounding pipeline / CSR file.
interface csr_access_unit_if;
    import csr_pkg::*;

    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_funct3;
    logic [11:0] req_csr;
    logic [4:0]  req_rs1_idx;
    logic [31:0] req_rs1_value;
    logic [4:0]  req_rd;

    logic [11:0] csr_number;
    csr_access_t csr_access_type;
    logic [31:0] csr_wdata;
    logic [31:0] csr_rdata;

    logic        wb_valid;
    logic        wb_ready;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        wb_illegal;

    modport slave (
        input  req_valid, req_funct3, req_csr, req_rs1_idx, req_rs1_value, req_rd,
        input  csr_rdata, wb_ready,
        output req_ready, csr_number, csr_access_type, csr_wdata,
        output wb_valid, wb_rd, wb_data, wb_illegal
    );

    modport master (
        output req_valid, req_funct3, req_csr, req_rs1_idx, req_rs1_value, req_rd,
        output csr_rdata, wb_ready,
        input  req_ready, csr_number, csr_access_type, csr_wdata,
        input  wb_valid, wb_rd, wb_data, wb_illegal
    );

endinterface

// File: rtl/csr_access_decode.sv
// Combinational Zicsr decode: funct3/rs1/csr -> bus access type, write operand, illegal flag.
// Optional CSR_ILLEGAL_CHECK_EN enables illegal-instruction detection.
module csr_access_decode
    import csr_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [4:0]  rs1_idx,
    input  logic [11:0] csr,
    input  logic [31:0] rs1_value,
    output csr_access_t access_type,
    output logic [31:0] wdata,
    output logic        illegal
);

    csr_access_t base_type;

    always_comb begin
        // NOTE: default assigned first so no path leaves base_type unassigned (no latch).
        base_type = CSR_READ_ONLY;
        case (funct3)
            FUNCT3_CSRRW, FUNCT3_CSRRWI: base_type = CSR_WRITE;
            FUNCT3_CSRRS, FUNCT3_CSRRSI: base_type = (rs1_idx != 5'd0) ? CSR_SET : CSR_READ_ONLY;
            FUNCT3_CSRRC, FUNCT3_CSRRCI: base_type = (rs1_idx != 5'd0) ? CSR_CLEAR : CSR_READ_ONLY;
            default:                     base_type = CSR_READ_ONLY;
        endcase
    end

    // Immediate forms carry the rs1 field itself as a zero-extended uimm.
    assign wdata = funct3[2] ? {27'd0, rs1_idx} : rs1_value;

`ifdef CSR_ILLEGAL_CHECK_EN
    // Address space 0xC00-0xFFF is read-only; any modifying access there is illegal.
    assign illegal = (funct3[1:0] == 2'b00) ||
                     ((base_type != CSR_READ_ONLY) && (csr[11:10] == 2'b11));
`else
    logic unused_csr;
    assign unused_csr = ^csr;
    assign illegal    = 1'b0;
`endif

    assign access_type = illegal ? CSR_READ_ONLY : base_type;

endmodule

// File: rtl/csr_access_unit.sv
// Zicsr execution unit: IDLE -> ACCESS (one cycle on the CSR bus) -> WB (held until consumed).
// Build option CSR_ILLEGAL_CHECK_EN (see csr_access_decode) adds illegal-instruction flagging.
module csr_access_unit
    import csr_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    csr_access_unit_if.slave  bus
);

    state_t      state_q, state_d;
    csr_req_t    req_q;
    logic [31:0] wb_data_q;
    logic        wb_illegal_q;

    csr_access_t dec_type;
    logic [31:0] dec_wdata;
    logic        dec_illegal;

    csr_access_decode u_decode (
        .funct3      (req_q.funct3),
        .rs1_idx     (req_q.rs1_idx),
        .csr         (req_q.csr),
        .rs1_value   (req_q.rs1_value),
        .access_type (dec_type),
        .wdata       (dec_wdata),
        .illegal     (dec_illegal)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (!reset_n) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (bus.req_valid) state_d = ST_ACCESS;
            ST_ACCESS: state_d = ST_WB;
            ST_WB:     if (bus.wb_ready) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Outside ACCESS the bus must read only: the responder commits on every edge.
    always_comb begin
        bus.req_ready       = (state_q == ST_IDLE);
        bus.wb_valid        = (state_q == ST_WB);
        bus.csr_access_type = (state_q == ST_ACCESS) ? dec_type : CSR_READ_ONLY;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            req_q        <= '0;
            wb_data_q    <= '0;
            wb_illegal_q <= 1'b0;
        end else begin
            if (state_q == ST_IDLE && bus.req_valid) begin
                req_q <= '{funct3:    bus.req_funct3,
                           csr:       bus.req_csr,
                           rs1_idx:   bus.req_rs1_idx,
                           rs1_value: bus.req_rs1_value,
                           rd:        bus.req_rd};
            end
            // Same edge that commits the write, so the pre-write value is captured.
            if (state_q == ST_ACCESS) begin
                wb_data_q    <= dec_illegal ? 32'd0 : bus.csr_rdata;
                wb_illegal_q <= dec_illegal;
            end
        end
    end

    assign bus.csr_number = req_q.csr;
    assign bus.csr_wdata  = dec_wdata;
    assign bus.wb_rd      = req_q.rd;
    assign bus.wb_data    = wb_data_q;
    assign bus.wb_illegal = wb_illegal_q;

endmodule
